// File: rtl/sram_frame_reader.sv
// Replays a stored raster frame from an asynchronous SRAM as a framed image token stream.
// Latency: each token reaches dvo 2 cycles after issue; done arrives start + 3 + R*(C+2+ROW_GAP) + 1.
// Backpressure: none. The stream is paced by the FSM, and downstream must accept every token.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, abort        frame launch pulse (ignored while busy) and clean early termination
//   base_addr, num_cols, num_rows  frame geometry, latched when a start is accepted
//   busy, done          frame in progress; done pulses together with FRAME_END on dvo
//   addr, oeb, web      registered SRAM address, output enable (active low), write enable (held at 1)
//   ram_data            SRAM read data
//   dvo, dtypeo, datao  output token stream

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd5
`endif

module sram_frame_reader #(
  parameter int ADDR_WIDTH = 21,
  parameter int DIM_WIDTH  = 11,
  parameter int ROW_GAP    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DIM_WIDTH-1:0]    num_cols,
  input  logic [DIM_WIDTH-1:0]    num_rows,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    oeb,
  output logic                    web,
  input  logic [15:0]             ram_data,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             datao
);

  // The gap counter only needs to count 0..ROW_GAP-1.
  localparam int GAP_W = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSTART,
    S_RSTART,
    S_PIXELS,
    S_REND,
    S_GAP,
    S_FEND
  } state_t;

  state_t                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    num_cols_q, num_rows_q;
  logic [DIM_WIDTH-1:0]    row_q, row_d;
  logic [DIM_WIDTH-1:0]    col_q, col_d;
  logic [DIM_WIDTH-1:0]    row_inc;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    abort_q, abort_d;
  logic                    accept;
  logic                    busy_q;

  // Token being issued this cycle.
  logic                    iss_vld;
  logic [`DTYPE_WIDTH-1:0] iss_type;
  logic [15:0]             iss_dat;
  logic                    iss_pix;

  // Issue stage (same edge as addr/oeb), capture stage, output stage.
  logic                    tok0_vld_q;
  logic [`DTYPE_WIDTH-1:0] tok0_type_q;
  logic [15:0]             tok0_dat_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    oeb_q;
  logic                    tok1_vld_q;
  logic [`DTYPE_WIDTH-1:0] tok1_type_q;
  logic [15:0]             tok1_dat_q;
  logic                    dvo_q;
  logic [`DTYPE_WIDTH-1:0] dtypeo_q;
  logic [15:0]             datao_q;
  logic                    done_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    abort_d  = abort_q;
    accept   = 1'b0;
    iss_vld  = 1'b0;
    iss_type = '0;
    iss_dat  = '0;
    row_inc  = row_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // busy stays high until the cycle after done, so a start that
        // lands during the output pipeline drain is still ignored.
        if (start && !busy_q) begin
          accept  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          ptr_d   = base_addr;
          abort_d = 1'b0;
          state_d = S_FSTART;
        end
      end
      S_FSTART: begin
        iss_vld  = 1'b1;
        iss_type = `DTYPE_FRAME_START;
        if (abort || num_rows_q == '0 || num_cols_q == '0) state_d = S_FEND;
        else                                                state_d = S_RSTART;
      end
      S_RSTART: begin
        iss_vld  = 1'b1;
        iss_type = `DTYPE_ROW_START;
        iss_dat  = 16'(row_q);
        col_d    = '0;
        if (abort) begin
          abort_d = 1'b1;
          state_d = S_REND;
        end else begin
          state_d = S_PIXELS;
        end
      end
      S_PIXELS: begin
        // The pixel of the cycle in which abort is seen is still issued.
        iss_vld  = 1'b1;
        iss_type = `DTYPE_PIXEL;
        ptr_d    = ptr_q + 1'b1;
        col_d    = col_q + 1'b1;
        if (abort) abort_d = 1'b1;
        if (abort || col_q == num_cols_q - 1'b1) state_d = S_REND;
      end
      S_REND: begin
        iss_vld  = 1'b1;
        iss_type = `DTYPE_ROW_END;
        row_d    = row_inc;
        gap_d    = '0;
        if (abort || abort_q)          state_d = S_FEND;
        else if (ROW_GAP > 0)          state_d = S_GAP;
        else if (row_inc != num_rows_q) state_d = S_RSTART;
        else                           state_d = S_FEND;
      end
      S_GAP: begin
        // row_q was already advanced by REND.
        if (abort)                  state_d = S_FEND;
        else if (gap_q == GAP_LAST) state_d = (row_q != num_rows_q) ? S_RSTART : S_FEND;
        else                        gap_d = gap_q + 1'b1;
      end
      S_FEND: begin
        iss_vld  = 1'b1;
        iss_type = `DTYPE_FRAME_END;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    iss_pix = iss_vld && (iss_type == `DTYPE_PIXEL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_cols_q  <= '0;
      num_rows_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      gap_q       <= '0;
      ptr_q       <= '0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      tok0_vld_q  <= 1'b0;
      tok0_type_q <= '0;
      tok0_dat_q  <= '0;
      addr_q      <= '0;
      oeb_q       <= 1'b1;
      tok1_vld_q  <= 1'b0;
      tok1_type_q <= '0;
      tok1_dat_q  <= '0;
      dvo_q       <= 1'b0;
      dtypeo_q    <= '0;
      datao_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;

      if (accept) begin
        num_cols_q <= num_cols;
        num_rows_q <= num_rows;
        busy_q     <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end

      // Issue stage: SRAM address goes out with the token.
      tok0_vld_q  <= iss_vld;
      tok0_type_q <= iss_type;
      tok0_dat_q  <= iss_dat;
      oeb_q       <= !iss_pix;
      if (iss_pix) addr_q <= ptr_q;

      // Capture stage: the SRAM has had one full cycle to respond.
      tok1_vld_q  <= tok0_vld_q;
      tok1_type_q <= tok0_type_q;
      tok1_dat_q  <= (tok0_vld_q && tok0_type_q == `DTYPE_PIXEL) ? ram_data : tok0_dat_q;

      // Output stage: type/data hold their last value on idle cycles.
      dvo_q  <= tok1_vld_q;
      done_q <= tok1_vld_q && (tok1_type_q == `DTYPE_FRAME_END);
      if (tok1_vld_q) begin
        dtypeo_q <= tok1_type_q;
        datao_q  <= tok1_dat_q;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign addr   = addr_q;
  assign oeb    = oeb_q;
  assign web    = 1'b1;
  assign dvo    = dvo_q;
  assign dtypeo = dtypeo_q;
  assign datao  = datao_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: token stream, frame latency, SRAM address/enable timing.
// The SRAM model returns the low 16 address bits, so pixel data is predictable.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 3
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 3'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 3'd2
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 3'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 3'd4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 3'd5
`endif

module tb_sram_frame_reader;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    abort;
  logic [20:0]             base_addr;
  logic [10:0]             num_cols;
  logic [10:0]             num_rows;
  logic                    busy;
  logic                    done;
  logic [20:0]             addr;
  logic                    oeb;
  logic                    web;
  logic [15:0]             ram_data;
  logic                    dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]             datao;

  int checks   = 0;
  int failures = 0;

  logic [18:0] tok_q[$];
  logic [18:0] exp_q[$];
  logic [20:0] addr_seen[$];
  int          oeb_lo_cnt = 0;
  int          timing_err = 0;
  int          web_err    = 0;
  logic        oeb_h1 = 1'b1;
  logic        oeb_h2 = 1'b1;
  int          lat;

  sram_frame_reader #(
    .ADDR_WIDTH (21),
    .DIM_WIDTH  (11),
    .ROW_GAP    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .num_cols  (num_cols),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .addr      (addr),
    .oeb       (oeb),
    .web       (web),
    .ram_data  (ram_data),
    .dvo       (dvo),
    .dtypeo    (dtypeo),
    .datao     (datao)
  );

  assign ram_data = addr[15:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired: checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: token log, SRAM reads, pixel timing vs oeb.
  always @(negedge clk) begin
    if (web !== 1'b1) web_err++;
    if (reset) begin
      oeb_h1 = 1'b1;
      oeb_h2 = 1'b1;
    end else begin
      if (((dvo === 1'b1) && (dtypeo == `DTYPE_PIXEL)) != (oeb_h2 == 1'b0)) timing_err++;
      if (dvo === 1'b1) tok_q.push_back({dtypeo, datao});
      if (oeb === 1'b0) begin
        oeb_lo_cnt++;
        addr_seen.push_back(addr);
      end
      oeb_h2 = oeb_h1;
      oeb_h1 = oeb;
    end
  end

  task automatic clear_logs();
    tok_q.delete();
    exp_q.delete();
    addr_seen.delete();
    oeb_lo_cnt = 0;
  endtask

  task automatic exp_tok(input logic [2:0] t, input logic [15:0] d);
    exp_q.push_back({t, d});
  endtask

  // Expected stream for a full frame of contiguous pixels.
  task automatic exp_frame(input logic [15:0] base, input int nc, input int nr);
    exp_tok(`DTYPE_FRAME_START, 16'h0);
    for (int r = 0; r < nr; r++) begin
      exp_tok(`DTYPE_ROW_START, 16'(r));
      for (int c = 0; c < nc; c++) exp_tok(`DTYPE_PIXEL, base + 16'(r * nc + c));
      exp_tok(`DTYPE_ROW_END, 16'h0);
    end
    exp_tok(`DTYPE_FRAME_END, 16'h0);
  endtask

  task automatic check_tokens(input string tag);
    check({tag, "_ntok"}, 32'(tok_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tok_q.size(); i++)
      check($sformatf("%s_tok%0d", tag, i), 32'(tok_q[i]), 32'(exp_q[i]));
  endtask

  // Launches a frame and counts edges from the accepting edge to done.
  // restart_at/abort_at drive a one-cycle pulse after edge n (0 = never).
  task automatic run_frame(input logic [20:0] ba, input logic [10:0] nc, input logic [10:0] nr,
                           input int restart_at, input int abort_at, output int latency);
    @(negedge clk);
    base_addr = ba;
    num_cols  = nc;
    num_rows  = nr;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    latency = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      start = (n == restart_at);
      if (n == restart_at) begin
        base_addr = 21'h0;
        num_cols  = 11'd7;
        num_rows  = 11'd9;
      end
      abort = (n == abort_at);
      if (done === 1'b1) begin
        latency = n;
        check("busy_at_done", 32'(busy), 32'd1);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    num_cols  = '0;
    num_rows  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_addr",   32'(addr),   32'd0);
    check("rst_oeb",    32'(oeb),    32'd1);
    check("rst_web",    32'(web),    32'd1);
    check("rst_dvo",    32'(dvo),    32'd0);
    check("rst_dtypeo", 32'(dtypeo), 32'd0);
    check("rst_datao",  32'(datao),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Main frame: 3 rows of 4 pixels from 0x100; 3 + 3*10 + 1 = 34.
    clear_logs();
    exp_frame(16'h0100, 4, 3);
    run_frame(21'h000100, 11'd4, 11'd3, 0, 0, lat);
    check("lat_main", 32'(lat), 32'd34);
    check("oeb_cnt_main", 32'(oeb_lo_cnt), 32'd12);
    check_tokens("main");

    // Zero rows, then zero columns: FS then FE only, 4 cycles.
    clear_logs();
    exp_tok(`DTYPE_FRAME_START, 16'h0);
    exp_tok(`DTYPE_FRAME_END, 16'h0);
    run_frame(21'h000200, 11'd5, 11'd0, 0, 0, lat);
    check("lat_rows0", 32'(lat), 32'd4);
    check("oeb_cnt_rows0", 32'(oeb_lo_cnt), 32'd0);
    check_tokens("rows0");

    clear_logs();
    exp_tok(`DTYPE_FRAME_START, 16'h0);
    exp_tok(`DTYPE_FRAME_END, 16'h0);
    run_frame(21'h000200, 11'd0, 11'd3, 0, 0, lat);
    check("lat_cols0", 32'(lat), 32'd4);
    check("oeb_cnt_cols0", 32'(oeb_lo_cnt), 32'd0);
    check_tokens("cols0");

    // Address wrap at the top of the 21-bit space.
    clear_logs();
    run_frame(21'h1FFFFE, 11'd4, 11'd1, 0, 0, lat);
    check("lat_wrap", 32'(lat), 32'd14);
    check("wrap_naddr", 32'(addr_seen.size()), 32'd4);
    if (addr_seen.size() == 4) begin
      check("wrap_addr0", 32'(addr_seen[0]), 32'h1FFFFE);
      check("wrap_addr1", 32'(addr_seen[1]), 32'h1FFFFF);
      check("wrap_addr2", 32'(addr_seen[2]), 32'h000000);
      check("wrap_addr3", 32'(addr_seen[3]), 32'h000001);
    end
    exp_tok(`DTYPE_FRAME_START, 16'h0);
    exp_tok(`DTYPE_ROW_START, 16'h0);
    exp_tok(`DTYPE_PIXEL, 16'hFFFE);
    exp_tok(`DTYPE_PIXEL, 16'hFFFF);
    exp_tok(`DTYPE_PIXEL, 16'h0000);
    exp_tok(`DTYPE_PIXEL, 16'h0001);
    exp_tok(`DTYPE_ROW_END, 16'h0);
    exp_tok(`DTYPE_FRAME_END, 16'h0);
    check_tokens("wrap");

    // Ignored restart at edge 6, abort seen at edge 15 (row 1, column 2).
    // Row 1 pixels issue at edges 13,14,15; ROW_END at 16, FRAME_END at 17, done at 19.
    clear_logs();
    exp_tok(`DTYPE_FRAME_START, 16'h0);
    exp_tok(`DTYPE_ROW_START, 16'h0);
    for (int c = 0; c < 4; c++) exp_tok(`DTYPE_PIXEL, 16'h0200 + 16'(c));
    exp_tok(`DTYPE_ROW_END, 16'h0);
    exp_tok(`DTYPE_ROW_START, 16'h1);
    for (int c = 0; c < 3; c++) exp_tok(`DTYPE_PIXEL, 16'h0204 + 16'(c));
    exp_tok(`DTYPE_ROW_END, 16'h0);
    exp_tok(`DTYPE_FRAME_END, 16'h0);
    run_frame(21'h000200, 11'd4, 11'd3, 5, 14, lat);
    check("lat_abort", 32'(lat), 32'd19);
    check("oeb_cnt_abort", 32'(oeb_lo_cnt), 32'd7);
    check_tokens("abort");

    // Reset in the middle of the pixel phase.
    clear_logs();
    @(negedge clk);
    base_addr = 21'h000300;
    num_cols  = 11'd8;
    num_rows  = 11'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("prerst_oeb", 32'(oeb), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_dvo",  32'(dvo),  32'd0);
    check("midrst_oeb",  32'(oeb),  32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    exp_frame(16'h0040, 2, 1);
    run_frame(21'h000040, 11'd2, 11'd1, 0, 0, lat);
    check("lat_fresh", 32'(lat), 32'd12);
    check_tokens("fresh");

    repeat (3) @(posedge clk);
    #1;
    check("pix_timing_errs", 32'(timing_err), 32'd0);
    check("web_errs", 32'(web_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
